tboom_pdst_release_unit: RTL

- Retire-side producer for the physical-register freelist. Takes up to two committing instructions per cycle and extracts the stale physical destinations they free.
- Buffers those stale pdsts in a small in-order queue.
- Drains up to two per cycle into the freelist's i0/i1 write ports, stalling while the freelist is full or restoring a checkpoint.

---
 rtl/tboom_pdst_release_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/tboom_pdst_release_unit.sv
// Retire-side release queue: collects stale physical destinations from up to two
// commits per cycle and drains up to two per cycle into the freelist write ports.
module tboom_pdst_release_unit #(
    parameter int DATA_WIDTH     = 6,
    parameter int ARCH_REG_WIDTH = 5,
    parameter int QUEUE_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          c0_valid,
    input  logic                          c0_has_dst,
    input  logic [ARCH_REG_WIDTH-1:0]     c0_ldst,
    input  logic [DATA_WIDTH-1:0]         c0_stale_pdst,
    input  logic                          c1_valid,
    input  logic                          c1_has_dst,
    input  logic [ARCH_REG_WIDTH-1:0]     c1_ldst,
    input  logic [DATA_WIDTH-1:0]         c1_stale_pdst,
    output logic                          commit_ready,
    input  logic                          fl_full,
    input  logic                          fl_restore,
    output logic                          fl_i0_write_enable,
    output logic [DATA_WIDTH-1:0]         fl_i0_data,
    output logic                          fl_i1_write_enable,
    output logic [DATA_WIDTH-1:0]         fl_i1_data,
    output logic [$clog2(QUEUE_DEPTH):0]  count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_p1;
    logic [PTR_W-1:0]      wr_ptr_p1;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;

    logic                  rel0;
    logic                  rel1;
    logic [1:0]            enq_req;
    logic [1:0]            enq_acc;
    logic [1:0]            deq;
    logic                  drop;
    logic                  stall;
    logic [CNT_W-1:0]      space;
    logic [DATA_WIDTH-1:0] first_data;

    // Writes to architectural x0 never free a physical register.
    assign rel0       = c0_valid && c0_has_dst && (c0_ldst != '0);
    assign rel1       = c1_valid && c1_has_dst && (c1_ldst != '0);
    assign enq_req    = {1'b0, rel0} + {1'b0, rel1};
    assign first_data = rel0 ? c0_stale_pdst : c1_stale_pdst;
    assign space      = CNT_W'(QUEUE_DEPTH) - count_q;
    assign stall      = fl_full || fl_restore;
    assign rd_ptr_p1  = rd_ptr + PTR_W'(1);
    assign wr_ptr_p1  = wr_ptr + PTR_W'(1);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        enq_acc = enq_req;
        drop    = 1'b0;
        // Space is judged on start-of-cycle occupancy; same-cycle drains do not help.
        if (space < CNT_W'(enq_req)) begin
            enq_acc = space[1:0];
            drop    = 1'b1;
        end
    end

    always_comb begin
        deq = 2'd0;
        if (!stall) begin
            if (count_q >= CNT_W'(2))      deq = 2'd2;
            else if (count_q == CNT_W'(1)) deq = 2'd1;
        end
    end

    assign fl_i0_write_enable = (deq != 2'd0);
    assign fl_i1_write_enable = (deq == 2'd2);
    assign fl_i0_data         = fl_i0_write_enable ? mem[rd_ptr]    : '0;
    assign fl_i1_data         = fl_i1_write_enable ? mem[rd_ptr_p1] : '0;
    assign commit_ready       = (space >= CNT_W'(2));
    assign count              = count_q;
    assign overflow           = overflow_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(enq_acc);
            rd_ptr  <= rd_ptr + PTR_W'(deq);
            count_q <= count_q + CNT_W'(enq_acc) - CNT_W'(deq);
            if (drop) overflow_q <= 1'b1;
        end
    end

    // NOTE: queue storage is deliberately not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (enq_acc != 2'd0) mem[wr_ptr]    <= first_data;
        if (enq_acc == 2'd2) mem[wr_ptr_p1] <= c1_stale_pdst;
    end

endmodule
